// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Read-side master for a sync_fifo-style buffer. Pops words from the FIFO
//   (registered read data, valid one cycle after the pop) and presents them on
//   a valid/ready stream in bursts. m_last marks the final beat of each burst.
//   A 2-entry output buffer keeps 1 word/cycle flowing under continuous
//   m_ready.
//
//   A burst starts from IDLE when fifo_count >= BURST_LEN (length BURST_LEN),
//   or on a flush pulse with fifo_count != 0 (length = fifo_count that cycle).
//
//   Optional feature macro: FIFO_RD_AUTOFLUSH_EN
//     defined   : after TIMEOUT idle cycles with words waiting and no trigger,
//                 an internal flush is raised.
//     undefined : only threshold or an external flush start a burst.
//
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   fifo_rd_en  out  pop request to FIFO (combinational)
//   fifo_data   in   FIFO read data, valid the cycle after an accepted pop
//   fifo_empty  in   FIFO empty flag
//   fifo_count  in   FIFO occupancy
//   flush       in   pulse: send all currently counted words as one burst
//   m_valid     out  output word valid (registered)
//   m_ready     in   consumer ready
//   m_data      out  output word (registered)
//   m_last      out  final beat of burst (registered)
//   busy        out  FSM not IDLE or buffer non-empty (registered)
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;

  // Output buffer: slot 0 is the head presented on m_*.
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic                last0_q, last0_d;
  logic                last1_q, last1_d;
  logic                busy_q, busy_d;

  logic                handshake;
  logic [1:0]          level;
  logic                pop_is_last;
  logic                start_burst;
  logic                flush_eff;

`ifdef FIFO_RD_AUTOFLUSH_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    flush_eff = flush || (idle_cnt_q == TIMEOUT_C);
  end

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == IDLE && fifo_count != '0 && !start_burst) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  always_comb begin
    flush_eff = flush;
  end
`endif

  always_comb begin
    handshake   = valid0_q && m_ready;
    // Words that will occupy the buffer once the in-flight read lands and any
    // head handshake this cycle completes; a new pop needs a free slot.
    level       = 2'(valid0_q) + 2'(valid1_q) + 2'(inflight_q) - 2'(handshake);
    fifo_rd_en  = (state_q == ISSUE) && !fifo_empty && (issued_q < len_q) &&
                  (level < 2'd2);
    pop_is_last = (issued_q + 1'b1) == len_q;
    start_burst = (state_q == IDLE) &&
                  ((fifo_count >= BURST_LEN_C) || (flush_eff && fifo_count != '0));
  end

  // FSM next state and burst bookkeeping
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    issued_d        = issued_q;
    inflight_d      = fifo_rd_en;
    inflight_last_d = fifo_rd_en && pop_is_last;

    if (fifo_rd_en) begin
      issued_d = issued_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (fifo_count >= BURST_LEN_C) begin
          state_d  = ISSUE;
          len_d    = BURST_LEN_C;
          issued_d = '0;
        end else if (flush_eff && fifo_count != '0) begin
          state_d  = ISSUE;
          len_d    = fifo_count;
          issued_d = '0;
        end
      end
      ISSUE: begin
        if (fifo_rd_en && pop_is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake && last0_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: retire the head first, then append the landing read word
  // into the first free slot, so ordering is preserved in one step.
  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    last0_d  = last0_q;
    last1_d  = last1_q;

    if (handshake) begin
      valid0_d = valid1_q;
      data0_d  = data1_q;
      last0_d  = last1_q;
      valid1_d = 1'b0;
      data1_d  = '0;
      last1_d  = 1'b0;
    end

    if (inflight_q) begin
      if (!valid0_d) begin
        valid0_d = 1'b1;
        data0_d  = fifo_data;
        last0_d  = inflight_last_q;
      end else begin
        valid1_d = 1'b1;
        data1_d  = fifo_data;
        last1_d  = inflight_last_q;
      end
    end
  end

  always_comb begin
    busy_d = (state_d != IDLE) || valid0_d || valid1_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      valid0_q        <= 1'b0;
      valid1_q        <= 1'b0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      valid0_q        <= valid0_d;
      valid1_q        <= valid1_d;
      data0_q         <= data0_d;
      data1_q         <= data1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
      busy_q          <= busy_d;
    end
  end

  assign m_valid = valid0_q;
  assign m_data  = data0_q;
  assign m_last  = last0_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader with a behavioural sync FIFO
//   (registered read data). Cycle indices in expectations are tick numbers
//   relative to the start of each scenario; tick 0 is the cycle whose inputs
//   load the FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_rd_en;
  logic [3:0] fifo_data  = '0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_count = '0;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       m_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_W   (4),
    .CNT_W    (4),
    .BURST_LEN(4),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  // Behavioural FIFO: pop on rd_en, read word appears the next cycle.
  logic [3:0] fq[$];
  int         wr_cnt = 0;
  logic [3:0] wr_vals[4];

  always @(posedge clk) begin
    logic [3:0] rd_word;
    rd_word = fifo_data;
    if (!reset_n) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) rd_word = fq.pop_front();
      for (int i = 0; i < wr_cnt; i++) fq.push_back(wr_vals[i]);
    end
    fifo_data  <= rd_word;
    fifo_count <= 4'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  // Per-scenario logs
  int         cyc;
  int         pc[$];
  logic [3:0] bd[$];
  logic       bl[$];
  int         bc[$];

  task clear_log();
    cyc = 0;
    pc.delete();
    bd.delete();
    bl.delete();
    bc.delete();
  endtask

  task tick(input logic rdy, input logic fl, input int wn,
            input logic [3:0] a, input logic [3:0] b,
            input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    m_ready    = rdy;
    flush      = fl;
    wr_cnt     = wn;
    wr_vals[0] = a;
    wr_vals[1] = b;
    wr_vals[2] = c;
    wr_vals[3] = d;
    #1;
    if (fifo_rd_en) pc.push_back(cyc);
    if (m_valid && m_ready) begin
      bd.push_back(m_data);
      bl.push_back(m_last);
      bc.push_back(cyc);
    end
    cyc++;
  endtask

  task test_reset();
    reset_n = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    wr_cnt  = 0;
    #3;
    checks++;
    if ({fifo_rd_en, m_valid, m_data, m_last, busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_init: got rd=%b v=%b d=%h l=%b busy=%b want all 0",
               fifo_rd_en, m_valid, m_data, m_last, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Mid-burst async reset with a word waiting on the output
    clear_log();
    tick(1'b0, 1'b0, 4, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 1; i <= 4; i++) tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'd1) begin
      failures++;
      $display("FAIL reset_pre: got v=%b d=%h want v=1 d=1", m_valid, m_data);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_data, m_last, busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: got rd=%b v=%b d=%h l=%b busy=%b want all 0",
               fifo_rd_en, m_valid, m_data, m_last, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
      checks++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_after: tick %0d got rd=%b busy=%b v=%b want 0",
                 i, fifo_rd_en, busy, m_valid);
      end
    end
  endtask

  task test_flush_empty();
    clear_log();
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty: got pops=%0d busy=%b want pops=0 busy=0",
               pc.size(), busy);
    end
  endtask

  task test_basic();
    clear_log();
    tick(1'b1, 1'b0, 4, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 1; i < 10; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 4) begin
      failures++;
      $display("FAIL basic_pops: got %0d want 4", pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pc[i] != 2 + i) begin
          failures++;
          $display("FAIL basic_pop_cyc[%0d]: got %0d want %0d", i, pc[i], 2 + i);
        end
      end
    end
    checks++;
    if (bd.size() != 4) begin
      failures++;
      $display("FAIL basic_beats: got %0d want 4", bd.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bd[i] !== 4'(i + 1) || bl[i] !== (i == 3) || bc[i] != 4 + i) begin
          failures++;
          $display("FAIL basic_beat[%0d]: got d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                   i, bd[i], bl[i], bc[i], 4'(i + 1), (i == 3), 4 + i);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: got busy=%b v=%b want 0 0", busy, m_valid);
    end
  endtask

  task test_backpressure();
    clear_log();
    tick(1'b1, 1'b0, 4, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 6; i <= 8; i++) begin
      tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 4'd3 || m_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: tick %0d got v=%b d=%h l=%b want v=1 d=3 l=0",
                 i, m_valid, m_data, m_last);
      end
    end
    for (int i = 9; i <= 12; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 4) begin
      failures++;
      $display("FAIL bp_pops: got %0d want 4", pc.size());
    end
    checks++;
    if (bd.size() != 4) begin
      failures++;
      $display("FAIL bp_beats: got %0d want 4", bd.size());
    end else begin
      checks++;
      if (bd[0] !== 4'd1 || bd[1] !== 4'd2 || bd[2] !== 4'd3 || bd[3] !== 4'd4 ||
          bc[2] != 9 || bc[3] != 10 || bl[2] !== 1'b0 || bl[3] !== 1'b1) begin
        failures++;
        $display("FAIL bp_order: got %h%h%h%h t3=%0d t4=%0d l=%b%b want 1234 t3=9 t4=10 l=01",
                 bd[0], bd[1], bd[2], bd[3], bc[2], bc[3], bl[2], bl[3]);
      end
    end
  endtask

  task test_occ_limit();
    clear_log();
    tick(1'b0, 1'b0, 4, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 1; i <= 7; i++) tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (m_data !== 4'd1 || m_valid !== 1'b1) begin
      failures++;
      $display("FAIL occ_hold: got v=%b d=%h want v=1 d=1", m_valid, m_data);
    end
    for (int i = 8; i <= 13; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 4) begin
      failures++;
      $display("FAIL occ_pops: got %0d want 4", pc.size());
    end else begin
      checks++;
      if (pc[0] != 2 || pc[1] != 3 || pc[2] != 8 || pc[3] != 9) begin
        failures++;
        $display("FAIL occ_pop_cyc: got %0d,%0d,%0d,%0d want 2,3,8,9",
                 pc[0], pc[1], pc[2], pc[3]);
      end
    end
    checks++;
    if (bd.size() != 4) begin
      failures++;
      $display("FAIL occ_beats: got %0d want 4", bd.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bd[i] !== 4'(i + 1) || bl[i] !== (i == 3) || bc[i] != 8 + i) begin
          failures++;
          $display("FAIL occ_beat[%0d]: got d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                   i, bd[i], bl[i], bc[i], 4'(i + 1), (i == 3), 8 + i);
        end
      end
    end
  endtask

  task test_flush_short();
    clear_log();
    tick(1'b1, 1'b0, 3, 4'd5, 4'd6, 4'd7, 4'd0);
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy_mid: got %b want 1", busy);
    end
    for (int i = 6; i <= 8; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 3) begin
      failures++;
      $display("FAIL flush_pops: got %0d want 3", pc.size());
    end
    checks++;
    if (bd.size() != 3) begin
      failures++;
      $display("FAIL flush_beats: got %0d want 3", bd.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bd[i] !== 4'(5 + i) || bl[i] !== (i == 2) || bc[i] != 4 + i) begin
          failures++;
          $display("FAIL flush_beat[%0d]: got d=%h l=%b t=%0d want d=%h l=%b t=%0d",
                   i, bd[i], bl[i], bc[i], 4'(5 + i), (i == 2), 4 + i);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy_end: got %b want 0", busy);
    end
  endtask

  task test_flush_threshold();
    logic [3:0] exp_d[6];
    logic       exp_l[6];
    int         exp_p[6];
    exp_d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_p = '{3, 4, 5, 6, 18, 19};
    clear_log();
    tick(1'b1, 1'b0, 3, 4'd1, 4'd2, 4'd3, 4'd0);
    tick(1'b1, 1'b0, 1, 4'd4, 4'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);                 // count=4 and flush together
    tick(1'b1, 1'b0, 2, 4'd9, 4'd10, 4'd0, 4'd0);    // writes during the burst
    for (int i = 4; i <= 6; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);                 // flush while draining
    for (int i = 8; i <= 16; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL thr_wait: got pops=%0d busy=%b want pops=4 busy=0", pc.size(), busy);
    end
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 18; i <= 23; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 6 || bd.size() != 6) begin
      failures++;
      $display("FAIL thr_counts: got pops=%0d beats=%0d want 6 6", pc.size(), bd.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (bd[i] !== exp_d[i] || bl[i] !== exp_l[i] || pc[i] != exp_p[i]) begin
          failures++;
          $display("FAIL thr_beat[%0d]: got d=%h l=%b pop=%0d want d=%h l=%b pop=%0d",
                   i, bd[i], bl[i], pc[i], exp_d[i], exp_l[i], exp_p[i]);
        end
      end
    end
  endtask

  task test_autoflush();
    clear_log();
    tick(1'b1, 1'b0, 2, 4'd5, 4'd6, 4'd0, 4'd0);
`ifdef FIFO_RD_AUTOFLUSH_EN
    for (int i = 1; i <= 24; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 2 || bd.size() != 2) begin
      failures++;
      $display("FAIL auto_counts: got pops=%0d beats=%0d want 2 2", pc.size(), bd.size());
    end else begin
      checks++;
      if (pc[0] != 18 || pc[1] != 19 || bd[0] !== 4'd5 || bd[1] !== 4'd6 ||
          bl[0] !== 1'b0 || bl[1] !== 1'b1 || bc[0] != 20 || bc[1] != 21) begin
        failures++;
        $display("FAIL auto_burst: got pops %0d,%0d d=%h%h l=%b%b t=%0d,%0d want 18,19 56 01 20,21",
                 pc[0], pc[1], bd[0], bd[1], bl[0], bl[1], bc[0], bc[1]);
      end
    end
`else
    for (int i = 1; i <= 100; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (pc.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL no_auto: got pops=%0d busy=%b want 0 0", pc.size(), busy);
    end
    tick(1'b1, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 102; i <= 107; i++) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (bd.size() != 2) begin
      failures++;
      $display("FAIL no_auto_flush: got beats=%0d want 2", bd.size());
    end else begin
      checks++;
      if (bd[0] !== 4'd5 || bd[1] !== 4'd6 || bl[1] !== 1'b1 || bc[0] != 104) begin
        failures++;
        $display("FAIL no_auto_data: got d=%h%h l=%b t=%0d want 56 1 104",
                 bd[0], bd[1], bl[1], bc[0]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_flush_empty();
    test_basic();
    test_backpressure();
    test_occ_limit();
    test_flush_short();
    test_flush_threshold();
    test_autoflush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
